// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sap_pkg
//  Description : Shared constants and mode encoding for the program counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sap_pkg;

    // Default counter and bus width in bits
    localparam int PC_WIDTH = 4;

    // Operating mode of the program counter
    typedef enum logic [0:0] {
        PC_RUN    = 1'b0,
        PC_HALTED = 1'b1
    } pc_mode_e;

endpackage : sap_pkg
`default_nettype wire

// File: rtl/pc_bus_driver.sv
`default_nettype none
// ============================================================================
//  Module      : pc_bus_driver
//  Description : Gates the counter value onto the shared bus. bus_out and
//                bus_drive are purely combinational (zero-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_bus_driver #(
    parameter int WIDTH = 4
) (
    input  logic             out_en,
    input  logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_drive
);

    // Drive the counter onto the bus only while enabled, zeros otherwise
    always_comb begin
        bus_out   = out_en ? pc_q : '0;
        bus_drive = out_en;
    end

endmodule : pc_bus_driver
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
//  Module      : program_counter
//  Description : Loadable, haltable program counter with bus output gating.
//                Update priority in RUN: halt > jump > count_en > hold.
//                Once HALTED only reset returns the counter to RUN.
//  Options     : PC_WRAP_FLAG_EN - when defined, builds the registered wrap
//                pulse; otherwise wrap is tied to 0 and has no register.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_counter
    import sap_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic             jump,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             out_en,
    input  logic             halt,
    output logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_drive,
    output logic             wrap,
    output logic             halted
);

    logic [WIDTH-1:0] r_pc;
    pc_mode_e         r_mode;

    // Counter value and RUN/HALTED mode; halt freezes the count on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= '0;
            r_mode <= PC_RUN;
        end else if (r_mode == PC_RUN) begin
            if (halt) begin
                r_mode <= PC_HALTED;
            end else if (jump) begin
                r_pc <= bus_in;
            end else if (count_en) begin
                r_pc <= r_pc + WIDTH'(1);
            end
        end
    end

`ifdef PC_WRAP_FLAG_EN
    logic w_inc;
    logic r_wrap;

    // A real increment happens only in RUN with no halt or jump pending
    assign w_inc = (r_mode == PC_RUN) && !halt && !jump && count_en;

    // Pulse for one cycle after an all-ones to zero increment; loads never wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_inc && (&r_pc);
        end
    end

    assign wrap = r_wrap;
`else
    assign wrap = 1'b0;
`endif

    assign pc_q   = r_pc;
    assign halted = (r_mode == PC_HALTED);

    pc_bus_driver #(
        .WIDTH (WIDTH)
    ) u_bus_driver (
        .out_en    (out_en),
        .pc_q      (r_pc),
        .bus_out   (bus_out),
        .bus_drive (bus_drive)
    );

endmodule : program_counter
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_counter
//  Description : Directed, table-driven bench for program_counter plus
//                hand-written sequences for reset, wrap and bus timing.
//  Options     : PC_WRAP_FLAG_EN - selects whether wrap pulses are expected.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter;

    localparam int W = 4;
`ifdef PC_WRAP_FLAG_EN
    localparam bit WRAP_ON = 1'b1;
`else
    localparam bit WRAP_ON = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         count_en;
    logic         jump;
    logic [W-1:0] bus_in;
    logic         out_en;
    logic         halt;
    logic [W-1:0] pc_q;
    logic [W-1:0] bus_out;
    logic         bus_drive;
    logic         wrap;
    logic         halted;

    int checks = 0;
    int errors = 0;

    program_counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_en  (count_en),
        .jump      (jump),
        .bus_in    (bus_in),
        .out_en    (out_en),
        .halt      (halt),
        .pc_q      (pc_q),
        .bus_out   (bus_out),
        .bus_drive (bus_drive),
        .wrap      (wrap),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ce;
        logic         j;
        logic         h;
        logic         oe;
        logic [W-1:0] bin;
        logic [W-1:0] e_pc;
        logic         e_wrap;   // value expected when the wrap flag is built
        logic         e_halt;
        logic [W-1:0] e_bus;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ce, input logic j, input logic h,
                         input logic oe, input logic [W-1:0] bin);
        count_en = ce;
        jump     = j;
        halt     = h;
        out_en   = oe;
        bus_in   = bin;
    endtask

    initial begin
        // Starting from pc_q=0 right after reset release
        //          ce    j     h     oe    bin   pc    wrap  halt  bus
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 4'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h2, 1'b0, 1'b0, 4'h2};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 4'h2, 1'b0, 1'b0, 4'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 4'h3, 1'b0, 1'b0, 4'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 4'hA, 1'b0, 1'b0, 4'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'hA, 1'b0, 1'b0, 4'hA};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 4'h5, 1'b0, 1'b0, 4'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h5, 1'b0, 1'b0, 4'h5};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 4'h0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 4'h7, 1'b0, 1'b0, 4'h0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h7, 1'b0, 1'b1, 4'h0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 1'b0, 1'b1, 4'h0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h7, 1'b0, 1'b1, 4'h0};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'h7, 1'b0, 1'b1, 4'h7};

        // Reset state, asserted from time zero
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        @(posedge clk); #1;
        check("rst_pc", 32'(pc_q), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_bus_off", 32'(bus_out), 32'h0);
        check("rst_drive_off", 32'(bus_drive), 32'h0);
        out_en = 1'b1; #1;
        check("rst_bus_on", 32'(bus_out), 32'h0);
        check("rst_drive_on", 32'(bus_drive), 32'h1);

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        rst_n = 1'b1;

        // Table-driven vectors: drive on negedge, check just after posedge
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].ce, vecs[i].j, vecs[i].h, vecs[i].oe, vecs[i].bin);
            @(posedge clk); #1;
            check($sformatf("v%0d_pc", i), 32'(pc_q), 32'(vecs[i].e_pc));
            check($sformatf("v%0d_wrap", i), 32'(wrap), 32'(vecs[i].e_wrap & WRAP_ON));
            check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_halt));
            check($sformatf("v%0d_bus", i), 32'(bus_out), 32'(vecs[i].e_bus));
            check($sformatf("v%0d_drive", i), 32'(bus_drive), 32'(vecs[i].oe));
        end

        // Reset pulse mid-cycle leaves HALTED without a clock edge
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        check("halt_rst_pc", 32'(pc_q), 32'h0);
        check("halt_rst_halted", 32'(halted), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Seventeen increments from 0: 1..15, 0, 1 with wrap after 15->0
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
            @(posedge clk); #1;
            check($sformatf("cnt%0d_pc", i), 32'(pc_q), 32'((i + 1) % 16));
            check($sformatf("cnt%0d_wrap", i), 32'(wrap), 32'((i == 15) && WRAP_ON));
        end

        // Bus output in the count cycle shows the pre-increment value
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
        #1;
        check("pre_inc_bus", 32'(bus_out), 32'h1);
        @(posedge clk); #1;
        check("post_inc_pc", 32'(pc_q), 32'h2);
        check("post_inc_bus", 32'(bus_out), 32'h2);

        // Asynchronous reset mid-run at pc_q=9, away from any edge
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h9);
        @(posedge clk); #1;
        check("jump9_pc", 32'(pc_q), 32'h9);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", 32'(pc_q), 32'h0);
        check("async_rst_halted", 32'(halted), 32'h0);
        @(posedge clk); #1;
        check("held_rst_pc", 32'(pc_q), 32'h0);

        // First update comes on the first rising edge after release
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_edge_pc", 32'(pc_q), 32'h1);

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_program_counter
`default_nettype wire
